// File: rtl/txarq_sched.sv
`default_nettype none
// ==========================================================================
// txarq_sched : per-LT_ADDR ARQ / remote-flow / flush scheduler, ACL TX path
// Revision    : 1.0
// ==========================================================================
module txarq_sched (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        ms_tslot_p,
  input  logic        tx_slot_p,
  input  logic [2:0]  tx_lt_addr,
  input  logic        regi_txdatready_p,
  input  logic [2:0]  regi_lt_addr,
  input  logic [15:0] regi_flushto,
  input  logic        rx_hdr_p,
  input  logic        dec_hecgood,
  input  logic [2:0]  dec_lt_addr,
  input  logic        dec_arqn,
  input  logic        dec_flow,
  input  logic        dec_seqn,
  input  logic        rx_pyend_p,
  input  logic        dec_crcgood,
  input  logic        rxbuf_empty,
  output logic        txpktype_data,
  output logic        txpk_seqn,
  output logic        txpk_arqn,
  output logic        sendnewpy,
  output logic [7:0]  ack_p,
  output logic [7:0]  flush_p,
  output logic [7:0]  rx_newpy_p,
  output logic        datready_err_p
);

  typedef enum logic [1:0] {IDLE = 2'd0, READY = 2'd1, WAIT_ACK = 2'd2} lt_state_t;

  lt_state_t [7:0]   state, state_nx;
  logic [7:0][15:0]  fcnt, fcnt_nx;
  logic [7:0]        retx, retx_nx, seqn_tx, seqn_tx_nx, flow_rem, flow_rem_nx;
  logic [7:0]        arqn_rx, arqn_rx_nx, seqn_rx, seqn_rx_nx;
  logic [2:0]        rx_lt, rx_lt_nx;
  logic              tx_ok, data_nx, seqn_nx, arqn_nx, sendnew_nx, err_nx;
  logic [7:0]        ack_nx, flush_nx, newpy_nx;

  always_comb begin
    tx_ok       = (state[tx_lt_addr] != IDLE) && flow_rem[tx_lt_addr];
    data_nx     = txpktype_data;
    seqn_nx     = txpk_seqn;
    arqn_nx     = txpk_arqn;
    sendnew_nx  = 1'b0;
    err_nx      = 1'b0;
    ack_nx      = '0;
    flush_nx    = '0;
    newpy_nx    = '0;
    state_nx    = state;
    fcnt_nx     = fcnt;
    retx_nx     = retx;
    seqn_tx_nx  = seqn_tx;
    flow_rem_nx = flow_rem;
    arqn_rx_nx  = arqn_rx;
    seqn_rx_nx  = seqn_rx;
    rx_lt_nx    = rx_lt;

    // TX header fields always reflect pre-update state of the addressed LT
    if (tx_slot_p) begin
      data_nx    = tx_ok;
      seqn_nx    = seqn_tx[tx_lt_addr];
      arqn_nx    = arqn_rx[tx_lt_addr];
      sendnew_nx = tx_ok && !retx[tx_lt_addr];
    end

    if (rx_hdr_p && dec_hecgood)
      rx_lt_nx = dec_lt_addr;

    for (int n = 0; n < 8; n++) begin
      if (tx_slot_p && tx_ok && (tx_lt_addr == n[2:0])) begin
        retx_nx[n]  = 1'b1;
        state_nx[n] = WAIT_ACK;
      end

      if (rx_hdr_p && dec_hecgood && (dec_lt_addr == n[2:0])) begin
        flow_rem_nx[n] = dec_flow;
        if (state[n] == WAIT_ACK) begin
          if (dec_arqn) begin
            state_nx[n]   = IDLE;
            seqn_tx_nx[n] = ~seqn_tx[n];
            ack_nx[n]     = 1'b1;
          end else begin
            state_nx[n] = READY;
          end
        end
      end

      // An acknowledge in the same slot takes precedence over the flush
      if (ms_tslot_p && (state[n] != IDLE)) begin
        if (fcnt[n] != 16'hFFFF)
          fcnt_nx[n] = fcnt[n] + 16'd1;
        if ((regi_flushto != 16'd0) && !ack_nx[n] &&
            (({1'b0, fcnt[n]} + 17'd1) >= {1'b0, regi_flushto})) begin
          state_nx[n]   = IDLE;
          seqn_tx_nx[n] = ~seqn_tx[n];
          flush_nx[n]   = 1'b1;
        end
      end

      if (regi_txdatready_p && (regi_lt_addr == n[2:0])) begin
        if ((state[n] == IDLE) || ack_nx[n] || flush_nx[n]) begin
          state_nx[n] = READY;
          retx_nx[n]  = 1'b0;
          fcnt_nx[n]  = 16'd0;
        end else begin
          err_nx = 1'b1;
        end
      end
    end

    if (rx_pyend_p) begin
      if (!dec_crcgood) begin
        arqn_rx_nx[rx_lt] = 1'b0;
      end else if (dec_seqn == seqn_rx[rx_lt]) begin
        arqn_rx_nx[rx_lt] = 1'b1;
      end else if (rxbuf_empty) begin
        arqn_rx_nx[rx_lt] = 1'b1;
        seqn_rx_nx[rx_lt] = dec_seqn;
        newpy_nx[rx_lt]   = 1'b1;
      end else begin
        arqn_rx_nx[rx_lt] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      for (int n = 0; n < 8; n++) begin
        state[n] <= IDLE;
        fcnt[n]  <= 16'd0;
      end
      retx           <= 8'h00;
      seqn_tx        <= 8'hFF;
      flow_rem       <= 8'hFF;
      arqn_rx        <= 8'h00;
      seqn_rx        <= 8'h00;
      rx_lt          <= 3'd0;
      txpktype_data  <= 1'b0;
      txpk_seqn      <= 1'b0;
      txpk_arqn      <= 1'b0;
      sendnewpy      <= 1'b0;
      ack_p          <= 8'h00;
      flush_p        <= 8'h00;
      rx_newpy_p     <= 8'h00;
      datready_err_p <= 1'b0;
    end else begin
      state          <= state_nx;
      fcnt           <= fcnt_nx;
      retx           <= retx_nx;
      seqn_tx        <= seqn_tx_nx;
      flow_rem       <= flow_rem_nx;
      arqn_rx        <= arqn_rx_nx;
      seqn_rx        <= seqn_rx_nx;
      rx_lt          <= rx_lt_nx;
      txpktype_data  <= data_nx;
      txpk_seqn      <= seqn_nx;
      txpk_arqn      <= arqn_nx;
      sendnewpy      <= sendnew_nx;
      ack_p          <= ack_nx;
      flush_p        <= flush_nx;
      rx_newpy_p     <= newpy_nx;
      datready_err_p <= err_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_txarq_sched.sv
`default_nettype none
// ==========================================================================
// tb_txarq_sched : table-driven directed bench for txarq_sched
// Revision       : 1.0
// ==========================================================================
module tb_txarq_sched;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        ms_tslot_p, tx_slot_p, regi_txdatready_p, rx_hdr_p, dec_hecgood;
  logic        dec_arqn, dec_flow, dec_seqn, rx_pyend_p, dec_crcgood, rxbuf_empty;
  logic [2:0]  tx_lt_addr, regi_lt_addr, dec_lt_addr;
  logic [15:0] regi_flushto;
  logic        txpktype_data, txpk_seqn, txpk_arqn, sendnewpy, datready_err_p;
  logic [7:0]  ack_p, flush_p, rx_newpy_p;

  always #5 clk_6M = ~clk_6M;

  txarq_sched dut (
    .clk_6M(clk_6M), .rstz(rstz), .ms_tslot_p(ms_tslot_p), .tx_slot_p(tx_slot_p),
    .tx_lt_addr(tx_lt_addr), .regi_txdatready_p(regi_txdatready_p), .regi_lt_addr(regi_lt_addr),
    .regi_flushto(regi_flushto), .rx_hdr_p(rx_hdr_p), .dec_hecgood(dec_hecgood),
    .dec_lt_addr(dec_lt_addr), .dec_arqn(dec_arqn), .dec_flow(dec_flow), .dec_seqn(dec_seqn),
    .rx_pyend_p(rx_pyend_p), .dec_crcgood(dec_crcgood), .rxbuf_empty(rxbuf_empty),
    .txpktype_data(txpktype_data), .txpk_seqn(txpk_seqn), .txpk_arqn(txpk_arqn),
    .sendnewpy(sendnewpy), .ack_p(ack_p), .flush_p(flush_p), .rx_newpy_p(rx_newpy_p),
    .datready_err_p(datready_err_p)
  );

  typedef struct packed {
    logic tx; logic [2:0] txlt; logic rdy; logic [2:0] rdylt; logic ms;
    logic hdr; logic hec; logic [2:0] dlt; logic arqn; logic flow;
    logic py; logic crc; logic dseqn; logic rxe;
  } stim_t;

  typedef struct packed {
    logic data; logic seqn; logic arq; logic snew;
    logic [7:0] ack; logic [7:0] flush; logic [7:0] newpy; logic err;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  vec_t vecs[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic stim_t s_tx(input logic [2:0] lt);
    stim_t s = '0; s.tx = 1'b1; s.txlt = lt; return s;
  endfunction
  function automatic stim_t s_rdy(input logic [2:0] lt);
    stim_t s = '0; s.rdy = 1'b1; s.rdylt = lt; return s;
  endfunction
  function automatic stim_t s_ms();
    stim_t s = '0; s.ms = 1'b1; return s;
  endfunction
  function automatic stim_t s_hdr(input logic hec, input logic [2:0] lt, input logic arqn, input logic flow);
    stim_t s = '0; s.hdr = 1'b1; s.hec = hec; s.dlt = lt; s.arqn = arqn; s.flow = flow; return s;
  endfunction
  function automatic stim_t s_py(input logic crc, input logic sq, input logic rxe);
    stim_t s = '0; s.py = 1'b1; s.crc = crc; s.dseqn = sq; s.rxe = rxe; return s;
  endfunction
  function automatic exp_t ex(input logic d, input logic sq, input logic a, input logic sn,
                              input logic [7:0] ack = 8'h00, input logic [7:0] fl = 8'h00,
                              input logic [7:0] np = 8'h00, input logic err = 1'b0);
    exp_t e; e.data = d; e.seqn = sq; e.arq = a; e.snew = sn;
    e.ack = ack; e.flush = fl; e.newpy = np; e.err = err; return e;
  endfunction

  function automatic vec_t v(input stim_t s, input exp_t e);
    vec_t r; r.s = s; r.e = e; return r;
  endfunction

  task automatic apply(input stim_t s);
    tx_slot_p = s.tx;   tx_lt_addr = s.txlt;
    regi_txdatready_p = s.rdy; regi_lt_addr = s.rdylt;
    ms_tslot_p = s.ms;
    rx_hdr_p = s.hdr;   dec_hecgood = s.hec; dec_lt_addr = s.dlt;
    dec_arqn = s.arqn;  dec_flow = s.flow;
    rx_pyend_p = s.py;  dec_crcgood = s.crc; dec_seqn = s.dseqn; rxbuf_empty = s.rxe;
  endtask

  task automatic check(input string name, input exp_t e);
    exp_t act;
    act = {txpktype_data, txpk_seqn, txpk_arqn, sendnewpy, ack_p, flush_p, rx_newpy_p, datready_err_p};
    n_chk++;
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic step(input stim_t s, input exp_t e, input string name);
    apply(s);
    @(posedge clk_6M); #1;
    apply('0);
    check(name, e);
  endtask

  initial begin
    apply('0);
    regi_flushto = 16'd0;
    repeat (3) @(posedge clk_6M);
    #1;
    check("reset_state", ex(0, 0, 0, 0));
    rstz = 1'b1;

    // Ack path, NAK/implicit NAK, flow control, RX payload handling, coincident events
    vecs.push_back(v(s_rdy(2),               ex(1'b0, 1'b0, 1'b0, 1'b0)));
    vecs.push_back(v(s_tx(2),                ex(1, 1, 0, 1)));
    vecs.push_back(v(s_hdr(1, 2, 1, 1),      ex(1, 1, 0, 0, 8'h04)));
    vecs.push_back(v(s_tx(2),                ex(0, 0, 0, 0)));
    vecs.push_back(v(s_rdy(2),               ex(0, 0, 0, 0)));
    vecs.push_back(v(s_tx(2),                ex(1, 0, 0, 1)));
    vecs.push_back(v(s_hdr(1, 2, 0, 1),      ex(1, 0, 0, 0)));
    vecs.push_back(v(s_tx(2),                ex(1, 0, 0, 0)));
    vecs.push_back(v(s_tx(2),                ex(1, 0, 0, 0)));
    vecs.push_back(v(s_rdy(2),               ex(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1'b1)));
    vecs.push_back(v(s_hdr(0, 2, 1, 1),      ex(1, 0, 0, 0)));
    vecs.push_back(v(s_hdr(1, 2, 1, 1),      ex(1, 0, 0, 0, 8'h04)));
    vecs.push_back(v(s_tx(2),                ex(0, 1, 0, 0)));
    vecs.push_back(v(s_hdr(1, 5, 0, 0),      ex(0, 1, 0, 0)));
    vecs.push_back(v(s_rdy(5),               ex(0, 1, 0, 0)));
    vecs.push_back(v(s_tx(5),                ex(0, 1, 0, 0)));
    vecs.push_back(v(s_hdr(1, 5, 0, 1),      ex(0, 1, 0, 0)));
    vecs.push_back(v(s_tx(5),                ex(1, 1, 0, 1)));
    vecs.push_back(v(s_hdr(1, 5, 1, 1),      ex(1, 1, 0, 0, 8'h20)));
    vecs.push_back(v(s_hdr(1, 3, 0, 1),      ex(1, 1, 0, 0)));
    vecs.push_back(v(s_py(1, 1, 1),          ex(1, 1, 0, 0, 8'h00, 8'h00, 8'h08)));
    vecs.push_back(v(s_py(1, 1, 1),          ex(1, 1, 0, 0)));
    vecs.push_back(v(s_tx(3),                ex(0, 1, 1, 0)));
    vecs.push_back(v(s_py(1, 0, 1),          ex(0, 1, 1, 0, 8'h00, 8'h00, 8'h08)));
    vecs.push_back(v(s_py(1, 1, 0),          ex(0, 1, 1, 0)));
    vecs.push_back(v(s_tx(3),                ex(0, 1, 0, 0)));
    vecs.push_back(v(s_py(1, 1, 1),          ex(0, 1, 0, 0, 8'h00, 8'h00, 8'h08)));
    vecs.push_back(v(s_tx(3),                ex(0, 1, 1, 0)));
    vecs.push_back(v(s_py(0, 0, 1),          ex(0, 1, 1, 0)));
    vecs.push_back(v(s_tx(3),                ex(0, 1, 0, 0)));
    vecs.push_back(v(s_rdy(2),               ex(0, 1, 0, 0)));
    vecs.push_back(v(s_tx(2),                ex(1, 1, 0, 1)));
    vecs.push_back(v(stim_t'(s_hdr(1, 2, 1, 1) | s_rdy(2)), ex(1, 1, 0, 0, 8'h04)));
    vecs.push_back(v(s_tx(2),                ex(1, 0, 0, 1)));
    vecs.push_back(v(stim_t'(s_hdr(1, 2, 1, 1) | s_rdy(6)), ex(1, 0, 0, 0, 8'h04)));
    vecs.push_back(v(s_tx(6),                ex(1, 1, 0, 1)));
    vecs.push_back(v(s_hdr(1, 6, 1, 1),      ex(1, 1, 0, 0, 8'h40)));

    foreach (vecs[i]) step(vecs[i].s, vecs[i].e, $sformatf("row%0d", i));

    // Flush timeout of 3 slots on LT 1 through a NAK and a retransmission
    regi_flushto = 16'd3;
    step(s_rdy(1),          ex(1, 1, 0, 0), "fl_rdy");
    step(s_tx(1),           ex(1, 1, 0, 1), "fl_tx");
    step(s_hdr(1, 1, 0, 1), ex(1, 1, 0, 0), "fl_nak");
    step(s_ms(),            ex(1, 1, 0, 0), "fl_ms1");
    step(s_tx(1),           ex(1, 1, 0, 0), "fl_retx");
    step(s_ms(),            ex(1, 1, 0, 0), "fl_ms2");
    step(s_ms(),            ex(1, 1, 0, 0, 8'h00, 8'h02), "fl_ms3");
    step(s_tx(1),           ex(0, 0, 0, 0), "fl_null");

    // Ack beats flush; ready coincident with flush is accepted
    regi_flushto = 16'd1;
    step(s_rdy(4),                              ex(0, 0, 0, 0), "pr_rdy");
    step(s_tx(4),                               ex(1, 1, 0, 1), "pr_tx");
    step(stim_t'(s_ms() | s_hdr(1, 4, 1, 1)),   ex(1, 1, 0, 0, 8'h10), "ack_vs_flush");
    step(s_tx(4),                               ex(0, 0, 0, 0), "pr_null");
    step(s_rdy(4),                              ex(0, 0, 0, 0), "pr_rdy2");
    step(stim_t'(s_ms() | s_rdy(4)),            ex(0, 0, 0, 0, 8'h00, 8'h10), "rdy_vs_flush");
    step(s_tx(4),                               ex(1, 1, 0, 1), "pr_tx2");

    // Asynchronous reset while LT 7 waits for ack with seqn_tx 0
    regi_flushto = 16'd0;
    step(s_rdy(7),          ex(1, 1, 0, 0), "rs_rdy");
    step(s_tx(7),           ex(1, 1, 0, 1), "rs_tx");
    step(s_hdr(1, 7, 1, 1), ex(1, 1, 0, 0, 8'h80), "rs_ack");
    step(s_rdy(7),          ex(1, 1, 0, 0), "rs_rdy2");
    step(s_tx(7),           ex(1, 0, 0, 1), "rs_tx2");
    rstz = 1'b0;
    #1;
    check("async_reset", ex(0, 0, 0, 0));
    @(posedge clk_6M); #1;
    rstz = 1'b1;
    step(s_tx(7),           ex(0, 1, 0, 0), "post_rst_null");
    step(s_rdy(7),          ex(0, 1, 0, 0), "post_rst_rdy");
    step(s_tx(7),           ex(1, 1, 0, 1), "post_rst_tx");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
